// File: rtl/skut_frame_arbiter.sv
// skut_frame_arbiter
// Shares the write port of the ping-pong SKUT frame RAM (2 pages x 128 bytes)
// between the SKUT former (0), the DDC channel writer (1) and the LCC writer (2).
// Round-robin grant, one-cycle write latency, page swap on each rising edge of
// the 8 kHz frame strobe, per-frame write count and sticky starvation flags.
module skut_frame_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic              iClk,
  input  logic              reset,
  input  logic              i8KHz,
  input  logic              iEn,
  input  logic              iErrClr,
  input  logic [2:0]        iReq,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [ADDR_W-1:0] iAddr2,
  input  logic [DATA_W-1:0] iData0,
  input  logic [DATA_W-1:0] iData1,
  input  logic [DATA_W-1:0] iData2,
  output logic [2:0]        oAck,
  output logic [ADDR_W:0]   oRamAddr,
  output logic [DATA_W-1:0] oRamData,
  output logic              oRamWrEn,
  output logic              oRdPage,
  output logic              oSwap,
  output logic [7:0]        oFrameWrCnt,
  output logic [2:0]        oWaitErr
);

  localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SET = WAIT_W'(MAX_WAIT - 1);

  // Strobe synchroniser: two metastability flops plus the edge register.
  logic sync_q1, sync_q2, sync_q3;
  logic strobe_rise;

  logic              wr_page;
  logic [1:0]        last_ptr;
  logic [7:0]        frame_cnt;
  logic [7:0]        frame_cnt_next;
  logic [WAIT_W-1:0] wait_cnt [3];

  logic [2:0]        eligible;
  logic              grant;
  logic [1:0]        win;
  logic [2:0]        win_onehot;
  logic [1:0]        cand0, cand1, cand2;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic [2:0]        starving;
  logic [2:0]        err_set;

  // Cyclic successor of a requester index (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] next_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign strobe_rise = sync_q2 & ~sync_q3;
  assign oRdPage     = ~wr_page;

  // Round-robin winner search starting just after the last granted requester.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    eligible   = iReq & ~oAck;
    cand0      = next_idx(last_ptr);
    cand1      = next_idx(cand0);
    cand2      = next_idx(cand1);
    grant      = iEn & (|eligible);
    win        = cand2;
    win_onehot = 3'b000;
    if (eligible[cand0])      win = cand0;
    else if (eligible[cand1]) win = cand1;
    if (grant) win_onehot = 3'(3'b001 << win);
  end

  // Address/data of the winning requester.
  always_comb begin
    addr_sel = iAddr2;
    data_sel = iData2;
    case (win)
      2'd0:    begin addr_sel = iAddr0; data_sel = iData0; end
      2'd1:    begin addr_sel = iAddr1; data_sel = iData1; end
      default: begin addr_sel = iAddr2; data_sel = iData2; end
    endcase
  end

  // Saturating frame count including any grant made this cycle, and the
  // per-requester starvation set condition.
  always_comb begin
    frame_cnt_next = (grant && frame_cnt != 8'hFF) ? frame_cnt + 8'd1 : frame_cnt;
    starving       = iReq & ~win_onehot;
    err_set        = 3'b000;
    for (int n = 0; n < 3; n++) begin
      if (starving[n] && wait_cnt[n] >= WAIT_SET) err_set[n] = 1'b1;
    end
  end

  // Grant pipeline: the decided write reaches the RAM port one cycle later.
  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      oRamWrEn <= 1'b0;
      oAck     <= 3'b000;
      oRamAddr <= '0;
      oRamData <= '0;
      last_ptr <= 2'd2;
    end else begin
      oRamWrEn <= grant;
      oAck     <= win_onehot;
      if (grant) begin
        oRamAddr <= {wr_page, addr_sel};
        oRamData <= data_sel;
        last_ptr <= win;
      end
    end
  end

  // Strobe synchroniser, page swap and frame write count.
  always_ff @(posedge iClk) begin
    if (reset) begin
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      sync_q3     <= 1'b0;
      wr_page     <= 1'b0;
      oSwap       <= 1'b0;
      oFrameWrCnt <= 8'd0;
      frame_cnt   <= 8'd0;
    end else begin
      sync_q1 <= i8KHz;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
      oSwap   <= strobe_rise;
      if (strobe_rise) begin
        // A grant in the swap cycle used the old page, so it closes this frame.
        wr_page     <= ~wr_page;
        oFrameWrCnt <= frame_cnt_next;
        frame_cnt   <= 8'd0;
      end else begin
        frame_cnt <= frame_cnt_next;
      end
    end
  end

  // Starvation wait counters and sticky flags; a same-cycle set beats the clear.
  always_ff @(posedge iClk) begin
    if (reset) begin
      for (int n = 0; n < 3; n++) wait_cnt[n] <= '0;
      oWaitErr <= 3'b000;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (!starving[n])              wait_cnt[n] <= '0;
        else if (wait_cnt[n] != WAIT_MAX) wait_cnt[n] <= wait_cnt[n] + 1'b1;
      end
      oWaitErr <= (iErrClr ? 3'b000 : oWaitErr) | err_set;
    end
  end

endmodule

// File: tb/tb_skut_frame_arbiter.sv
// Self-checking bench for skut_frame_arbiter. Requesters are fed from per-
// requester byte queues; expected RAM writes go into a scoreboard queue as
// stimulus is loaded and are popped whenever the DUT strobes oRamWrEn.
module tb_skut_frame_arbiter;

  logic       iClk;
  logic       reset;
  logic       i8KHz;
  logic       iEn;
  logic       iErrClr;
  logic [2:0] iReq;
  logic [6:0] iAddr0, iAddr1, iAddr2;
  logic [7:0] iData0, iData1, iData2;
  logic [2:0] oAck;
  logic [7:0] oRamAddr;
  logic [7:0] oRamData;
  logic       oRamWrEn;
  logic       oRdPage;
  logic       oSwap;
  logic [7:0] oFrameWrCnt;
  logic [2:0] oWaitErr;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } byte_t;

  typedef struct packed {
    logic [2:0] ack;
    logic [7:0] ram_addr;
    logic [7:0] data;
  } exp_t;

  byte_t drv_q0[$];
  byte_t drv_q1[$];
  byte_t drv_q2[$];
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  skut_frame_arbiter dut (
    .iClk        (iClk),
    .reset       (reset),
    .i8KHz       (i8KHz),
    .iEn         (iEn),
    .iErrClr     (iErrClr),
    .iReq        (iReq),
    .iAddr0      (iAddr0),
    .iAddr1      (iAddr1),
    .iAddr2      (iAddr2),
    .iData0      (iData0),
    .iData1      (iData1),
    .iData2      (iData2),
    .oAck        (oAck),
    .oRamAddr    (oRamAddr),
    .oRamData    (oRamData),
    .oRamWrEn    (oRamWrEn),
    .oRdPage     (oRdPage),
    .oSwap       (oSwap),
    .oFrameWrCnt (oFrameWrCnt),
    .oWaitErr    (oWaitErr)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Present the head of each requester queue; empty queue means no request.
  task automatic drive();
    iReq[0] = (drv_q0.size() != 0);
    iReq[1] = (drv_q1.size() != 0);
    iReq[2] = (drv_q2.size() != 0);
    if (drv_q0.size() != 0) begin iAddr0 = drv_q0[0].addr; iData0 = drv_q0[0].data; end
    if (drv_q1.size() != 0) begin iAddr1 = drv_q1[0].addr; iData1 = drv_q1[0].data; end
    if (drv_q2.size() != 0) begin iAddr2 = drv_q2[0].addr; iData2 = drv_q2[0].data; end
  endtask

  task automatic add_byte(input int n, input logic [6:0] a, input logic [7:0] d);
    byte_t b;
    b.addr = a;
    b.data = d;
    if (n == 0)      drv_q0.push_back(b);
    else if (n == 1) drv_q1.push_back(b);
    else             drv_q2.push_back(b);
  endtask

  task automatic push_exp(input int n, input logic page, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e.ack      = 3'(1 << n);
    e.ram_addr = {page, a};
    e.data     = d;
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge, score any write, then advance
  // the requesters that were acknowledged and drive the next inputs.
  task automatic step();
    exp_t e;
    @(negedge iClk);
    if (oRamWrEn) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got ack=%b addr=%h data=%h, required no write",
                 oAck, oRamAddr, oRamData);
      end else begin
        e = exp_q.pop_front();
        if ({oAck, oRamAddr, oRamData} !== {e.ack, e.ram_addr, e.data}) begin
          n_fail++;
          $display("FAIL sb_write: got ack=%b addr=%h data=%h, required ack=%b addr=%h data=%h",
                   oAck, oRamAddr, oRamData, e.ack, e.ram_addr, e.data);
        end
      end
    end
    if (oAck[0] && drv_q0.size() != 0) void'(drv_q0.pop_front());
    if (oAck[1] && drv_q1.size() != 0) void'(drv_q1.pop_front());
    if (oAck[2] && drv_q2.size() != 0) void'(drv_q2.pop_front());
    drive();
  endtask

  task automatic do_reset();
    drv_q0.delete();
    drv_q1.delete();
    drv_q2.delete();
    exp_q.delete();
    reset = 1'b1;
    drive();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({oAck, oRamAddr, oRamData, oRamWrEn, oSwap, oFrameWrCnt, oWaitErr, oRdPage} !==
        {3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got ack=%b addr=%h data=%h wren=%b swap=%b cnt=%0d err=%b rdpage=%b, required all 0 with rdpage=1",
               oAck, oRamAddr, oRamData, oRamWrEn, oSwap, oFrameWrCnt, oWaitErr, oRdPage);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    add_byte(0, 7'd18, 8'd220);
    push_exp(0, 1'b0, 7'd18, 8'd220);
    drive();
    step();
    n_checks++;
    if ({oRamWrEn, oAck, oRamAddr, oRamData} !== {1'b1, 3'b001, 8'h12, 8'd220}) begin
      n_fail++;
      $display("FAIL single_write: got wren=%b ack=%b addr=%h data=%0d, required wren=1 ack=001 addr=12 data=220",
               oRamWrEn, oAck, oRamAddr, oRamData);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (oRamWrEn !== 1'b0) begin
        n_fail++;
        $display("FAIL single_no_second: got wren=%b, required 0", oRamWrEn);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] a;
    logic [7:0] d;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      for (int n = 0; n < 3; n++) begin
        a = 7'(n * 32 + j);
        d = 8'($urandom_range(0, 255));
        add_byte(n, a, d);
        push_exp(n, 1'b0, a, d);
      end
    end
    drive();
    for (int k = 1; k <= 18; k++) begin
      step();
      n_checks++;
      if (oRamWrEn !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_continuous: cycle %0d got wren=%b, required 1", k, oRamWrEn);
      end
    end
    repeat (2) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_swap();
    logic [6:0] a;
    logic [7:0] d;
    int         kk;
    do_reset();
    // Grants alternate 0,1 every cycle; strobe rises after sample 6, so the
    // swap-cycle grant is grant 9 and writes 10.. use page 1.
    for (int j = 0; j < 8; j++) begin
      for (int n = 0; n < 2; n++) begin
        kk = 2 * j + n + 1;
        a  = 7'(n * 64 + j);
        d  = 8'($urandom_range(0, 255));
        add_byte(n, a, d);
        push_exp(n, (kk <= 9) ? 1'b0 : 1'b1, a, d);
      end
    end
    drive();
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (oRdPage !== 1'b1) begin
          n_fail++;
          $display("FAIL swap_rdpage_before: got %b, required 1", oRdPage);
        end
      end
      if (k == 6) i8KHz = 1'b1;
      if (k == 8 || k == 10) begin
        n_checks++;
        if (oSwap !== 1'b0) begin
          n_fail++;
          $display("FAIL swap_no_pulse: cycle %0d got oSwap=%b, required 0", k, oSwap);
        end
      end
      if (k == 9) begin
        n_checks++;
        if ({oSwap, oRdPage, oFrameWrCnt} !== {1'b1, 1'b0, 8'd9}) begin
          n_fail++;
          $display("FAIL swap_pulse: got swap=%b rdpage=%b cnt=%0d, required swap=1 rdpage=0 cnt=9",
                   oSwap, oRdPage, oFrameWrCnt);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL swap_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    i8KHz = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_starvation();
    do_reset();
    iEn = 1'b0;
    add_byte(1, 7'd5, 8'h5A);
    drive();
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if ({oRamWrEn, oWaitErr} !== {1'b0, (k >= 8) ? 3'b010 : 3'b000}) begin
        n_fail++;
        $display("FAIL starve_wait: cycle %0d got wren=%b err=%b, required wren=0 err=%b",
                 k, oRamWrEn, oWaitErr, (k >= 8) ? 3'b010 : 3'b000);
      end
    end
    push_exp(1, 1'b0, 7'd5, 8'h5A);
    iEn     = 1'b1;
    iErrClr = 1'b1;
    step();
    iErrClr = 1'b0;
    n_checks++;
    if ({oWaitErr, oAck} !== {3'b000, 3'b010}) begin
      n_fail++;
      $display("FAIL starve_clear: got err=%b ack=%b, required err=000 ack=010", oWaitErr, oAck);
    end
    repeat (2) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL starve_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    add_byte(0, 7'h01, 8'hA1);
    add_byte(1, 7'h02, 8'hB2);
    add_byte(2, 7'h03, 8'hC3);
    push_exp(0, 1'b0, 7'h01, 8'hA1);
    drive();
    step();
    // Requester 1 would win the grant decided now; reset discards it.
    reset = 1'b1;
    add_byte(0, 7'h04, 8'hD4);
    drive();
    step();
    n_checks++;
    if ({oAck, oRamAddr, oRamData, oRamWrEn, oSwap, oFrameWrCnt, oWaitErr, oRdPage} !==
        {3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ack=%b addr=%h data=%h wren=%b swap=%b cnt=%0d err=%b rdpage=%b, required all 0 with rdpage=1",
               oAck, oRamAddr, oRamData, oRamWrEn, oSwap, oFrameWrCnt, oWaitErr, oRdPage);
    end
    reset = 1'b0;
    push_exp(0, 1'b0, 7'h04, 8'hD4);
    push_exp(1, 1'b0, 7'h02, 8'hB2);
    push_exp(2, 1'b0, 7'h03, 8'hC3);
    step();
    n_checks++;
    if (oAck !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_first_grant: got ack=%b, required 001", oAck);
    end
    repeat (3) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_count_saturation();
    logic [6:0] a;
    logic [7:0] d;
    do_reset();
    for (int j = 0; j < 150; j++) begin
      for (int n = 0; n < 2; n++) begin
        a = 7'(j % 128);
        d = 8'($urandom_range(0, 255));
        add_byte(n, a, d);
        push_exp(n, 1'b0, a, d);
      end
    end
    drive();
    repeat (300) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sat_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    i8KHz = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({oSwap, oFrameWrCnt} !== {1'b1, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_count: got swap=%b cnt=%0d, required swap=1 cnt=255", oSwap, oFrameWrCnt);
    end
    i8KHz = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    reset   = 1'b1;
    i8KHz   = 1'b0;
    iEn     = 1'b1;
    iErrClr = 1'b0;
    iReq    = 3'b000;
    iAddr0  = '0; iAddr1 = '0; iAddr2 = '0;
    iData0  = '0; iData1 = '0; iData2 = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_swap();
    test_starvation();
    test_reset_mid_write();
    test_count_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skut_frame_arbiter.md
Name: skut_frame_arbiter

Overview:
- Shares the single write port of the ping-pong SKUT frame RAM (2 pages x 128 bytes) between three writers: the SKUT former, the DDC channel writer and the LCC writer.
- Arbitrates round-robin, stamps each write with the current write page, and swaps pages on every rising edge of the 8 kHz frame strobe.
- Reports per-frame write counts and sticky starvation flags for the telemetry status word.

Parameters:
- ADDR_W, 7, requester byte address width; RAM address is ADDR_W+1 bits.
- DATA_W, 8, data byte width.
- MAX_WAIT, 8, cycles a request may stay pending before its starvation flag sets.

Ports:
- iClk, in, 1, system clock.
- reset, in, 1, synchronous, active-high reset.
- i8KHz, in, 1, frame strobe, asynchronous to iClk.
- iEn, in, 1, grant enable; when low, no new grants are issued.
- iErrClr, in, 1, one-cycle pulse that clears oWaitErr.
- iReq, in, 3, write request per requester; bit0 = SKUT, bit1 = DDC, bit2 = LCC.
- iAddr0/iAddr1/iAddr2, in, ADDR_W each, byte address per requester.
- iData0/iData1/iData2, in, DATA_W each, byte data per requester.
- oAck, out, 3, one-cycle write-accepted pulse per requester.
- oRamAddr, out, ADDR_W+1, {write page, byte address}.
- oRamData, out, DATA_W, RAM write data.
- oRamWrEn, out, 1, RAM write strobe.
- oRdPage, out, 1, page the frame reader may use; always the inverse of the write page.
- oSwap, out, 1, one-cycle pulse in the cycle the write page toggles.
- oFrameWrCnt, out, 8, number of grants in the frame just closed.
- oWaitErr, out, 3, sticky starvation flag per requester.

Behaviour:
- Reset (synchronous, active-high) sets:
  - all outputs to 0, so oRdPage = 1 and the write page is 0;
  - all internal counters to 0;
  - the synchroniser to 0;
  - the last-grant pointer to 2, so requester 0 has first priority.
- Strobe sync: i8KHz passes through 2 flip-flops plus an edge register. A rising edge is detected 3 cycles after the input change.
- Swap: in edge-detect cycle E:
  - the write page toggles (new value visible in E+1);
  - oSwap = 1 during E+1;
  - oRdPage follows the page.
- Arbitration, evaluated every cycle:
  - Eligible set = iReq & ~oAck, so the requester acked in the previous cycle is excluded.
  - If iEn = 1 and the eligible set is non-empty, the winner is the first eligible index after the last-grant pointer, searching cyclically.
  - The pointer updates to the winner.
- Latency: exactly 1 cycle. A grant decided in cycle t produces all of the following in t+1:
  - oRamWrEn = 1;
  - oAck[winner] = 1;
  - oRamAddr = {page at t, iAddrW at t};
  - oRamData = iDataW at t.
- Requester handshake:
  - Hold iReq, iAddr and iData stable until oAck.
  - Drop iReq, or present the next byte, in the cycle after oAck.
  - Maximum per-requester rate is 1 write per 2 cycles.
  - Dropping iReq before oAck withdraws the request with no write.
- Grant in the swap cycle: a grant decided in cycle E uses the old page and counts toward the closing frame.
- Frame count:
  - The internal counter increments on each grant and saturates at 255.
  - In cycle E: oFrameWrCnt <= counter + (grant in E), saturated at 255; the counter clears to 0.
- Starvation:
  - Per-requester wait counter increments each cycle iReq[n] = 1 and n is not granted.
  - It clears on grant or when iReq[n] = 0.
  - When it reaches MAX_WAIT, oWaitErr[n] sets and stays set.
  - iErrClr clears all flags; if a flag's set condition holds in the same cycle as iErrClr, set wins.
- iEn low:
  - Requests stay pending, wait counters keep running, and page swaps still occur.
  - An already-decided grant still completes in the next cycle.
- Reset mid-write: the pending grant is discarded, no oRamWrEn follows, and the pointer returns to 2.

Test Plan:
1. Reset, then iReq = 3'b111 held continuously with iEn = 1 → grant order 0,1,2,0,1,2…; oRamWrEn = 1 every cycle; each oAck bit pulses once per 3 cycles; addresses and data are the ones captured 1 cycle earlier.
2. Only iReq[0] = 1, iAddr0 = 7'd18, iData0 = 8'd220, requester drops iReq after ack → one write, oRamAddr = 8'h12, oRamData = 220, oAck = 3'b001 at t+1; no second write.
3. Toggle i8KHz, with a requester writing during edge-detect cycle E → that write lands on the old page; from E+1 writes use the new page; oSwap pulses in E+1; oRdPage flips; oFrameWrCnt equals the grant count including cycle E.
4. Hold iEn = 0 with iReq[1] = 1 for 10 cycles → oWaitErr = 3'b010 after 8 cycles; no RAM writes. Then pulse iErrClr with iEn = 1 → flag clears and the write completes.
5. Issue 300 grants within one frame → at the next swap oFrameWrCnt = 255 (saturated).
6. Assert reset in the cycle a grant is decided → no oRamWrEn the next cycle; all outputs 0; oRdPage = 1; the next arbitration starts at requester 0.
